// File: rtl/id_ex_issue.sv
// Decode-and-issue stage: decodes a MIPS instruction into an ALU select code and operand
// pair, and holds it in the ID/EX register with load-use bubbles, stall hold and flush.
module id_ex_issue #(
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    input  logic             stall,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [SEL_W-1:0] ex_alusel,
    output logic [31:0]      ex_reg1,
    output logic [31:0]      ex_reg2,
    output logic [31:0]      ex_imm,
    output logic [4:0]       ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic [31:0]      ex_pc,
    output logic             illegal_instr
);
    localparam logic [SEL_W-1:0] SEL_NOP = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_ADD = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_SUB = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_AND = SEL_W'(3);
    localparam logic [SEL_W-1:0] SEL_OR  = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_SLT = SEL_W'(5);
    localparam logic [SEL_W-1:0] SEL_LW  = SEL_W'(6);
    localparam logic [SEL_W-1:0] SEL_SW  = SEL_W'(7);
    localparam logic [SEL_W-1:0] SEL_BEQ = SEL_W'(8);
    localparam logic [SEL_W-1:0] SEL_J   = SEL_W'(9);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [31:0]      simm;
    logic             dec_legal, dec_uses_rt, dec_rw, dec_mr, dec_mw;
    logic [SEL_W-1:0] dec_sel;
    logic [4:0]       dec_rd;
    logic [31:0]      dec_r1, dec_r2, dec_imm;
    logic             hazard;

    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [31:0]      reg1_q, reg1_d, reg2_q, reg2_d, imm_q, imm_d, pc_q, pc_d;
    logic [4:0]       rd_q, rd_d;
    logic             rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;
    logic             illegal_q, illegal_d;

    assign opcode  = if_instr[31:26];
    assign funct   = if_instr[5:0];
    assign simm    = {{16{if_instr[15]}}, if_instr[15:0]};
    assign rs_addr = if_instr[25:21];
    assign rt_addr = if_instr[20:16];

    always_comb begin
        dec_legal   = 1'b1;
        dec_uses_rt = 1'b0;
        dec_sel     = SEL_NOP;
        dec_rw      = 1'b0;
        dec_mr      = 1'b0;
        dec_mw      = 1'b0;
        dec_rd      = 5'd0;
        dec_r1      = 32'd0;
        dec_r2      = 32'd0;
        dec_imm     = 32'd0;
        case (opcode)
            6'h00: begin
                dec_uses_rt = 1'b1;
                dec_rw      = 1'b1;
                dec_rd      = if_instr[15:11];
                dec_r1      = rs_data;
                dec_r2      = rt_data;
                case (funct)
                    6'h20:   dec_sel = SEL_ADD;
                    6'h22:   dec_sel = SEL_SUB;
                    6'h24:   dec_sel = SEL_AND;
                    6'h25:   dec_sel = SEL_OR;
                    6'h2A:   dec_sel = SEL_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'h23: begin
                dec_sel = SEL_LW;
                dec_rw  = 1'b1;
                dec_mr  = 1'b1;
                dec_rd  = rt_addr;
                dec_r1  = rs_data;
                dec_r2  = simm;
                dec_imm = simm;
            end
            6'h2B: begin
                dec_uses_rt = 1'b1;
                dec_sel     = SEL_SW;
                dec_mw      = 1'b1;
                dec_r1      = rs_data;
                dec_r2      = simm;
                dec_imm     = simm;
            end
            6'h04: begin
                dec_uses_rt = 1'b1;
                dec_sel     = SEL_BEQ;
                dec_r1      = rs_data;
                dec_r2      = rt_data;
                dec_imm     = simm;
            end
            6'h02: begin
                dec_sel = SEL_J;
                dec_imm = {4'b0000, if_instr[25:0], 2'b00};
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // A load in EX cannot forward in time; $0 is hardwired so it never conflicts.
    assign hazard = valid_q && mr_q && (rd_q != 5'd0) && if_valid &&
                    ((rd_q == rs_addr) || ((rd_q == rt_addr) && dec_uses_rt));
    assign id_stall = hazard || stall;

    always_comb begin
        valid_d   = 1'b0;
        sel_d     = SEL_NOP;
        reg1_d    = 32'd0;
        reg2_d    = 32'd0;
        imm_d     = 32'd0;
        rd_d      = 5'd0;
        rw_d      = 1'b0;
        mr_d      = 1'b0;
        mw_d      = 1'b0;
        pc_d      = 32'd0;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
            sel_d   = sel_q;
            reg1_d  = reg1_q;
            reg2_d  = reg2_q;
            imm_d   = imm_q;
            rd_d    = rd_q;
            rw_d    = rw_q;
            mr_d    = mr_q;
            mw_d    = mw_q;
            pc_d    = pc_q;
        end else if (hazard) begin
            valid_d = 1'b0;
        end else if (if_valid) begin
            if (dec_legal) begin
                valid_d = 1'b1;
                sel_d   = dec_sel;
                reg1_d  = dec_r1;
                reg2_d  = dec_r2;
                imm_d   = dec_imm;
                rd_d    = dec_rd;
                rw_d    = dec_rw;
                mr_d    = dec_mr;
                mw_d    = dec_mw;
                pc_d    = if_pc;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            sel_q     <= SEL_NOP;
            reg1_q    <= 32'd0;
            reg2_q    <= 32'd0;
            imm_q     <= 32'd0;
            rd_q      <= 5'd0;
            rw_q      <= 1'b0;
            mr_q      <= 1'b0;
            mw_q      <= 1'b0;
            pc_q      <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            sel_q     <= sel_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            imm_q     <= imm_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            mr_q      <= mr_d;
            mw_q      <= mw_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_alusel     = sel_q;
    assign ex_reg1       = reg1_q;
    assign ex_reg2       = reg2_q;
    assign ex_imm        = imm_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = rw_q;
    assign ex_memread    = mr_q;
    assign ex_memwrite   = mw_q;
    assign ex_pc         = pc_q;
    assign illegal_instr = illegal_q;
endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-and-issue stage for the pipelined CPU: takes a fetched MIPS instruction and its register-file operands, produces the ALU select code and operand pair the execute-stage ALU consumes, and holds them in the ID/EX pipeline register. It owns load-use hazard detection (bubble insertion plus fetch stall), downstream stall hold and branch/jump flush. It is the producer end of the ALU `alusel`/`reg1`/`reg2` interface.

## Interface
- SEL_W, 4, width of the ALU select code
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  32  PC of that instruction
- rs_addr  out  5  combinational, = if_instr[25:21]
- rt_addr  out  5  combinational, = if_instr[20:16]
- rs_data  in  32  register-file read data for rs_addr (same cycle)
- rt_data  in  32  register-file read data for rt_addr (same cycle)
- stall  in  1  downstream stall: hold ID/EX register
- flush  in  1  branch/jump taken: kill ID/EX contents
- id_stall  out  1  combinational; fetch must hold if_instr/if_pc
- ex_valid, ex_alusel[SEL_W], ex_reg1[32], ex_reg2[32], ex_imm[32], ex_rd[5], ex_regwrite, ex_memread, ex_memwrite, ex_pc[32]  out  registered ID/EX fields
- illegal_instr  out  1  sticky: an unsupported valid instruction was decoded

## Operation
- ALU select codes (shared defines): nop 0, add 1, sub 2, and 3, or 4, slt 5, lw 6, sw 7, beq 8, j 9.
- Decode: opcode 0x00 with funct 0x20/0x22/0x24/0x25/0x2A → add/sub/and/or/slt, ex_rd = instr[15:11], regwrite 1. Opcode 0x23 → lw, ex_rd = rt, regwrite 1, memread 1. 0x2B → sw, memwrite 1. 0x04 → beq. 0x02 → j.
- Operands: reg1 = rs_data, reg2 = rt_data for R-type and beq; lw/sw: reg1 = rs_data, reg2 = sign-extended instr[15:0]; j: reg1 = reg2 = 0.
- ex_imm: sign-extended instr[15:0] for lw/sw/beq; {4'b0, instr[25:0], 2'b00} for j; 0 otherwise. ex_rd = 0 whenever regwrite = 0.
- Unsupported opcode/funct with if_valid: issue bubble, set illegal_instr (cleared only by reset).
- Bubble = ex_valid 0, ex_alusel nop, all control bits 0, ex_rd 0, data fields 0.
- Load-use hazard: ex_valid && ex_memread && ex_rd != 0 && if_valid && (ex_rd == rs_addr || (ex_rd == rt_addr && instruction uses rt as source, i.e. R-type, beq, sw)). While hazard: id_stall = 1, bubble issued into ID/EX.
- id_stall = hazard || stall.
- Per-edge priority: flush → bubble; else stall → hold all ID/EX fields; else hazard → bubble; else if_valid → decoded instruction; else bubble.
- Flush and stall together: flush wins (ID/EX becomes bubble).
- Register $0 never creates a hazard.

## Timing
- Reset (async assert, any time including mid-stall): all ex_* outputs 0, ex_alusel nop, illegal_instr 0. Release synchronous to clk; first issue on first edge after release.
- Latency: instruction accepted on edge N appears on ex_* after edge N, one cycle.
- Load-use: exactly one bubble; hazard clears next cycle because lw moves past EX, dependent instruction issues on following edge.
- rs_addr/rt_addr/id_stall combinational from current inputs and ID/EX state; no other combinational path to outputs.
- Throughput: one instruction per cycle absent stall/hazard/flush.

## Test plan
- Reset: hold rst_n=0 with if_valid=1 add → all ex_* 0, ex_alusel 0, ex_valid 0; release, next edge ex_alusel 1.
- add $3,$1,$2 (0x00221820) with rs_data 5, rt_data 7 → next cycle ex_alusel 1, reg1 5, reg2 7, ex_rd 3, regwrite 1.
- lw $4,-4($1) (0x8C24FFFC) → ex_alusel 6, reg2 0xFFFFFFFC, memread 1, ex_rd 4; then sub $5,$4,$2 → id_stall 1 one cycle, one bubble, sub issues next cycle with ex_alusel 2.
- stall=1 for 3 cycles with or issued → ex_* unchanged all 3 cycles; stall and flush together → bubble.
- j 0x0000100 (0x08000100) → ex_alusel 9, reg1=reg2=0, ex_imm 0x400; opcode 0x3F → bubble, illegal_instr 1 and stays 1 until reset.
